// File: rtl/cpu_inst_prefetch.sv
// Instruction prefetcher: issues up to MAX_OUTSTANDING pipelined reads and queues
// returned instructions with their PCs; jumps flush the queue and drop stale responses.
module cpu_inst_prefetch #(
  parameter int XLEN            = 32,
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_jmp_en,
  input  logic [XLEN-1:0] i_jmp_pc,
  output logic            o_mem_req,
  output logic [XLEN-1:0] o_mem_addr,
  input  logic            i_mem_ready,
  input  logic [XLEN-1:0] i_mem_data,
  input  logic            i_mem_valid,
  output logic [XLEN-1:0] o_inst_data,
  output logic [XLEN-1:0] o_inst_pc,
  output logic            o_inst_valid,
  input  logic            i_inst_ready,
  output logic            o_busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [XLEN-1:0]  fifo_data_q [FIFO_DEPTH];
  logic [XLEN-1:0]  fifo_data_d [FIFO_DEPTH];
  logic [XLEN-1:0]  fifo_pc_q   [FIFO_DEPTH];
  logic [XLEN-1:0]  fifo_pc_d   [FIFO_DEPTH];

  logic            mem_accept;
  logic            push;
  logic            pop;
  logic [CNT_W:0]  committed;
  logic [XLEN-1:0] jmp_target;
  logic            unused_jmp_lsbs;

  assign unused_jmp_lsbs = ^i_jmp_pc[1:0];
  assign jmp_target      = {i_jmp_pc[XLEN-1:2], 2'b00};

  // Slots already promised to live requests plus queued entries must leave room in the FIFO.
  assign committed = {1'b0, inflight_q - drop_q} + {1'b0, count_q};

  assign o_mem_req    = !i_rst && !i_jmp_en && (inflight_q < MAX_C) && (committed < DEPTH_C);
  assign o_mem_addr   = fetch_pc_q;
  assign o_inst_valid = (count_q != '0) && !i_jmp_en;
  assign o_inst_data  = fifo_data_q[rd_ptr_q];
  assign o_inst_pc    = fifo_pc_q[rd_ptr_q];
  assign o_busy       = (inflight_q != '0);

  always_comb begin
    mem_accept  = o_mem_req && i_mem_ready;
    push        = i_mem_valid && (drop_q == '0) && !i_jmp_en;
    pop         = o_inst_valid && i_inst_ready;
    fetch_pc_d  = fetch_pc_q;
    resp_pc_d   = resp_pc_q;
    drop_d      = drop_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fifo_data_d = fifo_data_q;
    fifo_pc_d   = fifo_pc_q;
    inflight_d  = inflight_q + CNT_W'(mem_accept) - CNT_W'(i_mem_valid);
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);

    if (mem_accept) fetch_pc_d = fetch_pc_q + XLEN'(4);
    if (i_mem_valid && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);

    if (push) begin
      fifo_data_d[wr_ptr_q] = i_mem_data;
      fifo_pc_d[wr_ptr_q]   = resp_pc_q;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      resp_pc_d             = resp_pc_q + XLEN'(4);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    // Everything still in flight after this cycle belongs to the old stream.
    if (i_jmp_en) begin
      fetch_pc_d = jmp_target;
      resp_pc_d  = jmp_target;
      drop_d     = inflight_d;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fetch_pc_q  <= RESET_PC;
      resp_pc_q   <= RESET_PC;
      inflight_q  <= '0;
      drop_q      <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_data_q <= '{default: '0};
      fifo_pc_q   <= '{default: '0};
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      resp_pc_q   <= resp_pc_d;
      inflight_q  <= inflight_d;
      drop_q      <= drop_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_data_q <= fifo_data_d;
      fifo_pc_q   <= fifo_pc_d;
    end
  end

endmodule

// File: tb/tb_cpu_inst_prefetch.sv
// Bench for cpu_inst_prefetch: in-order memory model with configurable latency,
// expected-instruction queue filled on request acceptance, drained by a monitor.
module tb_cpu_inst_prefetch;

  localparam int MAX_OUT = 2;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_jmp_en = 1'b0;
  logic [31:0] i_jmp_pc = '0;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        i_mem_ready = 1'b0;
  logic [31:0] i_mem_data = '0;
  logic        i_mem_valid = 1'b0;
  logic [31:0] o_inst_data;
  logic [31:0] o_inst_pc;
  logic        o_inst_valid;
  logic        i_inst_ready = 1'b0;
  logic        o_busy;

  cpu_inst_prefetch #(
    .XLEN(32), .FIFO_DEPTH(4), .MAX_OUTSTANDING(MAX_OUT), .RESET_PC(32'h0)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_jmp_en(i_jmp_en), .i_jmp_pc(i_jmp_pc),
    .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .i_mem_ready(i_mem_ready),
    .i_mem_data(i_mem_data), .i_mem_valid(i_mem_valid),
    .o_inst_data(o_inst_data), .o_inst_pc(o_inst_pc), .o_inst_valid(o_inst_valid),
    .i_inst_ready(i_inst_ready), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { logic [31:0] addr; int due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;

  req_t        pend[$];
  exp_t        exp_q[$];
  logic [31:0] model_pc = '0;
  int          cyc = 0;
  int          accept_cnt = 0;
  int          mem_rdy_pct = 100;
  int          lat_cfg = 1;
  bit          lat_rand = 1'b0;
  int          compared = 0;
  int          mismatched = 0;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory model and request-side scoreboard.
  initial begin
    req_t r;
    int   lat;
    forever begin
      @(negedge i_clk);
      cyc++;
      if (!i_rst && pend.size() > 0 && pend[0].due <= cyc) begin
        r = pend.pop_front();
        i_mem_valid = 1'b1;
        i_mem_data  = data_of(r.addr);
      end else begin
        i_mem_valid = 1'b0;
        i_mem_data  = $urandom;
      end
      i_mem_ready = !i_rst && ($urandom_range(99) < mem_rdy_pct);
      #2;
      if (i_rst) begin
        pend.delete();
        exp_q.delete();
        model_pc   = 32'h0;
        accept_cnt = 0;
      end else if (i_jmp_en) begin
        check("req_during_jmp", 32'(o_mem_req), 32'h0);
        exp_q.delete();
        model_pc = {i_jmp_pc[31:2], 2'b00};
      end else if (o_mem_req && i_mem_ready) begin
        check("mem_addr", o_mem_addr, model_pc);
        lat = lat_rand ? $urandom_range(1, 5) : lat_cfg;
        pend.push_back('{addr: o_mem_addr, due: cyc + lat});
        exp_q.push_back('{pc: model_pc, data: data_of(model_pc)});
        model_pc = model_pc + 32'd4;
        accept_cnt++;
        check("outstanding_le_max", 32'(pend.size() <= MAX_OUT), 32'h1);
      end
    end
  end

  // Output monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      #2;
      if (!i_rst && o_inst_valid && i_inst_ready) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_inst: got pc 0x%08h, expected no instruction", o_inst_pc);
        end else begin
          e = exp_q.pop_front();
          check("inst_pc", o_inst_pc, e.pc);
          check("inst_data", o_inst_data, e.data);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    i_jmp_en = 1'b0;
    cycles(3);
    check("rst_mem_req", 32'(o_mem_req), 32'h0);
    check("rst_inst_valid", 32'(o_inst_valid), 32'h0);
    check("rst_busy", 32'(o_busy), 32'h0);
    i_rst = 1'b0;
  endtask

  task automatic jump(input logic [31:0] target);
    i_jmp_en = 1'b1;
    i_jmp_pc = target;
    @(negedge i_clk);
    i_jmp_en = 1'b0;
  endtask

  task automatic wait_valid(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge i_clk);
      ok = o_inst_valid;
    end
    if (!ok) check(name, 32'h0, 32'h1);
  endtask

  initial begin
    bit ok;
    // Streaming at full rate
    do_reset();
    i_inst_ready = 1'b1;
    mem_rdy_pct = 100;
    lat_cfg = 1;
    cycles(20);

    // Consumer stalled: exactly FIFO_DEPTH requests, then drain and resume at 0x10
    do_reset();
    i_inst_ready = 1'b0;
    cycles(12);
    check("stall_accepts", 32'(accept_cnt), 32'd4);
    check("stall_req_low", 32'(o_mem_req), 32'h0);
    check("stall_head_pc", o_inst_pc, 32'h0);
    i_inst_ready = 1'b1;
    cycles(10);

    // Jump with 0x8 and 0xC in flight
    do_reset();
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge i_clk);
      ok = (model_pc == 32'h8);
    end
    check("reach_pc8", 32'(ok), 32'h1);
    lat_cfg = 6;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge i_clk);
      #3;
      ok = (pend.size() == 2) && (pend[0].addr == 32'h8) && (pend[1].addr == 32'hC);
    end
    check("two_inflight", 32'(ok), 32'h1);
    @(negedge i_clk);
    jump(32'h103);
    check("redirect_addr", o_mem_addr, 32'h100);
    lat_cfg = 1;
    wait_valid("jmp_wait_timeout", ok);
    if (ok) check("jmp_first_pc", o_inst_pc, 32'h100);

    // Jump coinciding with a response while a pop is pending
    lat_cfg = 2;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge i_clk);
      #1;
      if (i_mem_valid && o_inst_valid && i_inst_ready) begin
        i_jmp_en = 1'b1;
        i_jmp_pc = 32'h200;
        ok = 1'b1;
      end
    end
    check("coincident_found", 32'(ok), 32'h1);
    @(negedge i_clk);
    i_jmp_en = 1'b0;
    check("jmp_flush_empty", 32'(o_inst_valid), 32'h0);
    cycles(15);

    // Back-to-back jumps: the later target wins
    jump(32'h40);
    i_jmp_en = 1'b1;
    i_jmp_pc = 32'h80;
    @(negedge i_clk);
    i_jmp_en = 1'b0;
    wait_valid("dbl_jmp_timeout", ok);
    if (ok) check("dbl_jmp_pc", o_inst_pc, 32'h80);
    cycles(10);

    // Fetch PC wrap-around
    lat_cfg = 1;
    jump(32'hFFFF_FFF9);
    check("wrap_start_addr", o_mem_addr, 32'hFFFF_FFF8);
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge i_clk);
      ok = o_inst_valid && (o_inst_pc == 32'h0);
    end
    check("wrap_pc0_delivered", 32'(ok), 32'h1);

    // Random stalls, latencies and jumps
    mem_rdy_pct = 70;
    lat_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge i_clk);
      i_inst_ready = ($urandom_range(99) < 75);
      if ($urandom_range(99) < 4) begin
        i_jmp_en = 1'b1;
        i_jmp_pc = $urandom;
      end else begin
        i_jmp_en = 1'b0;
      end
    end
    @(negedge i_clk);
    i_jmp_en = 1'b0;

    // Reset in the middle of traffic, then more random traffic
    do_reset();
    for (int i = 0; i < 40; i++) begin
      @(negedge i_clk);
      i_inst_ready = ($urandom_range(99) < 75);
    end

    // Stop issuing and drain everything
    mem_rdy_pct = 0;
    i_inst_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge i_clk);
      #3;
      ok = (exp_q.size() == 0) && (pend.size() == 0);
    end
    check("drain_empty", 32'(exp_q.size()), 32'h0);
    cycles(3);
    check("drain_busy", 32'(o_busy), 32'h0);
    check("drain_valid", 32'(o_inst_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
